// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and defaults for the register-file access arbiter
package reg_arb_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_MOV, OP_SWAP} reg_op_e;
    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, RESP} arb_state_e;
endpackage

// File: rtl/reg_access_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant selection, pointer advances past the winner on accept
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    logic [IW-1:0] ptr_q, ptr_d, kk;
    // first requester at or after the pointer wins; pointer moves only when the grant is taken
    always_comb begin
        any = 1'b0;
        grant_idx = '0;
        kk = '0;
        for (int i = 0; i < N; i++) begin
            kk = IW'((int'(ptr_q) + i) % N);
            if (!any && req[kk]) begin
                any = 1'b1;
                grant_idx = kk;
            end
        end
        grant = any ? (N'(1) << grant_idx) : '0;
        ptr_d = (accept && any) ? ((int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1) : ptr_q;
    end
    // pointer register
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: shares the register-file ports among requesters and sequences READ/WRITE/MOV/SWAP
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*2-1:0]      req_op,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rs,
    input  logic [NUM_REQ*DATA_W-1:0] req_imm,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rf_sel_in,
    output logic [ADDR_W-1:0]         rf_sel_out,
    output logic                      rf_we,
    output logic                      rf_oe,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    arb_state_e state_q, state_d;
    reg_op_e op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d, rs_q, rs_d;
    logic [DATA_W-1:0] imm_q, imm_d, tmp0_q, tmp0_d, tmp1_q, tmp1_d;
    logic [GW-1:0] g_q, g_d, g_idx;
    logic [NUM_REQ-1:0] grant;
    logic any;
    logic [1:0] op_a [NUM_REQ];
    logic [ADDR_W-1:0] rd_a [NUM_REQ], rs_a [NUM_REQ];
    logic [DATA_W-1:0] imm_a [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g]  = req_op[g*2 +: 2];
        assign rd_a[g]  = req_rd[g*ADDR_W +: ADDR_W];
        assign rs_a[g]  = req_rs[g*ADDR_W +: ADDR_W];
        assign imm_a[g] = req_imm[g*DATA_W +: DATA_W];
    end
    rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
        .clk(clk),
        .reset(reset),
        .req(req_valid),
        .accept(state_q == IDLE && !reset),
        .grant(grant),
        .grant_idx(g_idx),
        .any(any)
    );
    // op sequencing: one register-file micro-step per state, all outputs forced low under reset
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        rd_d = rd_q;
        rs_d = rs_q;
        imm_d = imm_q;
        g_d = g_q;
        tmp0_d = tmp0_q;
        tmp1_d = tmp1_q;
        req_ready = '0;
        resp_valid = '0;
        resp_data = '0;
        busy = !reset && state_q != IDLE;
        rf_sel_in = '0;
        rf_sel_out = '0;
        rf_we = 1'b0;
        rf_oe = 1'b0;
        rf_wdata = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: if (any) begin
                    req_ready = grant;
                    op_d = reg_op_e'(op_a[g_idx]);
                    rd_d = rd_a[g_idx];
                    rs_d = rs_a[g_idx];
                    imm_d = imm_a[g_idx];
                    g_d = g_idx;
                    state_d = S1;
                end
                S1: if (op_q == OP_WRITE) begin
                    rf_we = 1'b1;
                    rf_sel_in = rd_q;
                    rf_wdata = imm_q;
                    state_d = RESP;
                end else begin
                    rf_oe = 1'b1;
                    rf_sel_out = rs_q;
                    tmp0_d = rf_rdata;
                    state_d = (op_q == OP_READ) ? RESP : S2;
                end
                S2: if (op_q == OP_MOV) begin
                    rf_we = 1'b1;
                    rf_sel_in = rd_q;
                    rf_wdata = tmp0_q;
                    state_d = RESP;
                end else begin
                    rf_oe = 1'b1;
                    rf_sel_out = rd_q;
                    tmp1_d = rf_rdata;
                    state_d = S3;
                end
                S3: begin
                    rf_we = 1'b1;
                    rf_sel_in = rd_q;
                    rf_wdata = tmp0_q;
                    state_d = S4;
                end
                S4: begin
                    rf_we = 1'b1;
                    rf_sel_in = rs_q;
                    rf_wdata = tmp1_q;
                    state_d = RESP;
                end
                RESP: begin
                    resp_valid = NUM_REQ'(1) << g_q;
                    resp_data = (op_q == OP_WRITE) ? imm_q : (op_q == OP_SWAP) ? tmp1_q : tmp0_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state, latched command and temporaries
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q <= OP_READ;
            rd_q <= '0;
            rs_q <= '0;
            imm_q <= '0;
            g_q <= '0;
            tmp0_q <= '0;
            tmp1_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            rd_q <= rd_d;
            rs_q <= rs_d;
            imm_q <= imm_d;
            g_q <= g_d;
            tmp0_q <= tmp0_d;
            tmp1_q <= tmp1_d;
        end
    end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: scoreboard bench with an architectural register model and micro-step expectations
module tb_reg_access_arbiter;
    localparam int N = 2, DW = 8, AW = 3;
    logic clk = 1'b0;
    logic reset, busy, rf_we, rf_oe, rf_init;
    logic [N-1:0] req_valid, req_ready, resp_valid;
    logic [2*N-1:0] req_op;
    logic [N*AW-1:0] req_rd, req_rs;
    logic [N*DW-1:0] req_imm;
    logic [DW-1:0] resp_data, rf_wdata, rf_rdata;
    logic [AW-1:0] rf_sel_in, rf_sel_out;
    logic [1:0] c_op [N];
    logic [2:0] c_rd [N], c_rs [N];
    logic [7:0] c_imm [N];
    logic [7:0] rf [8];
    logic [7:0] mregs [8];
    typedef struct {
        int g;
        int acc;
        int n;
        logic [3:0] we;
        logic [3:0][2:0] idx;
        logic [3:0][7:0] wd;
        logic [7:0] exp;
    } op_t;
    op_t sb [$];
    int checks = 0, errors = 0, cyc = 0, tmo = 0, mptr = 0;
    int acc_cnt [N];
    int seen [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_op[g*2 +: 2] = c_op[g];
        assign req_rd[g*AW +: AW] = c_rd[g];
        assign req_rs[g*AW +: AW] = c_rs[g];
        assign req_imm[g*DW +: DW] = c_imm[g];
    end

    reg_access_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_imm(req_imm),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
        .rf_sel_in(rf_sel_in), .rf_sel_out(rf_sel_out), .rf_we(rf_we), .rf_oe(rf_oe),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // register file model: combinational read, write on the clock edge
    always @(posedge clk) begin
        if (rf_init) for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        else if (rf_we) rf[rf_sel_in] <= rf_wdata;
    end
    assign rf_rdata = rf[rf_sel_out];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // monitor: predicts grants, micro-steps and responses; compares on the falling edge
    initial begin
        op_t r;
        int k, s, eg, c;
        logic [7:0] a, b;
        bit inflight;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("rst_outputs", int'({busy, rf_we, rf_oe, req_ready, resp_valid, rf_sel_in, rf_sel_out, rf_wdata, resp_data}), 0);
                sb.delete();
                mptr = 0;
                continue;
            end
            chk("drv_timeout", tmo, 0);
            inflight = sb.size() > 0;
            chk("busy", int'(busy), int'(inflight));
            if (inflight) begin
                k = cyc - sb[0].acc;
                if (k >= 1 && k <= sb[0].n) begin
                    s = k - 1;
                    if (sb[0].we[s])
                        chk("step_write", int'({rf_we, rf_oe, rf_sel_in, rf_sel_out, rf_wdata}), int'({2'b10, sb[0].idx[s], 3'b000, sb[0].wd[s]}));
                    else
                        chk("step_read", int'({rf_we, rf_oe, rf_sel_in, rf_sel_out, rf_wdata}), int'({2'b01, 3'b000, sb[0].idx[s], 8'h00}));
                    chk("early_resp", int'(resp_valid), 0);
                end else begin
                    chk("resp_valid", int'(resp_valid), 1 << sb[0].g);
                    chk("resp_data", int'(resp_data), int'(sb[0].exp));
                    chk("resp_rf_quiet", int'({rf_we, rf_oe, rf_sel_in, rf_sel_out, rf_wdata}), 0);
                    for (int j = 0; j < sb[0].n; j++) if (sb[0].we[j]) mregs[sb[0].idx[j]] = sb[0].wd[j];
                    void'(sb.pop_front());
                end
            end else begin
                chk("idle_quiet", int'({rf_we, rf_oe, rf_sel_in, rf_sel_out, rf_wdata, resp_valid, resp_data}), 0);
            end
            if (sb.size() == 0)
                for (int i = 0; i < 8; i++) chk("regfile", int'(rf[i]), int'(mregs[i]));
            eg = -1;
            if (!inflight)
                for (int j = 0; j < N; j++) begin
                    c = (mptr + j) % N;
                    if (eg < 0 && req_valid[c]) eg = c;
                end
            chk("req_ready", int'(req_ready), (eg < 0) ? 0 : (1 << eg));
            if (eg >= 0) begin
                a = mregs[c_rs[eg]];
                b = mregs[c_rd[eg]];
                r.g = eg;
                r.acc = cyc;
                r.we = '0;
                r.idx = '0;
                r.wd = '0;
                case (c_op[eg])
                    2'd0: begin r.n = 1; r.idx[0] = c_rs[eg]; r.exp = a; end
                    2'd1: begin r.n = 1; r.we[0] = 1'b1; r.idx[0] = c_rd[eg]; r.wd[0] = c_imm[eg]; r.exp = c_imm[eg]; end
                    2'd2: begin r.n = 2; r.idx[0] = c_rs[eg]; r.we[1] = 1'b1; r.idx[1] = c_rd[eg]; r.wd[1] = a; r.exp = a; end
                    default: begin
                        r.n = 4;
                        r.idx[0] = c_rs[eg];
                        r.idx[1] = c_rd[eg];
                        r.we[2] = 1'b1; r.idx[2] = c_rd[eg]; r.wd[2] = a;
                        r.we[3] = 1'b1; r.idx[3] = c_rs[eg]; r.wd[3] = b;
                        r.exp = b;
                    end
                endcase
                sb.push_back(r);
                mptr = (eg + 1) % N;
                acc_cnt[eg]++;
            end
        end
    end

    task automatic set_cmd(input int i, input int op, input int rd, input int rs, input int imm);
        c_op[i] = 2'(op);
        c_rd[i] = 3'(rd);
        c_rs[i] = 3'(rs);
        c_imm[i] = 8'(imm);
    endtask

    task automatic wait_total(input int target);
        int t = 0;
        while (acc_cnt[0] + acc_cnt[1] < target && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt[0] + acc_cnt[1] < target) tmo = 1;
    endtask

    task automatic issue(input int i, input int op, input int rd, input int rs, input int imm);
        set_cmd(i, op, rd, rs, imm);
        req_valid[i] = 1'b1;
        wait_total(acc_cnt[0] + acc_cnt[1] + 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic settle();
        repeat (7) @(posedge clk);
        #1;
    endtask

    // directed scenarios, mid-op reset, then randomized traffic
    initial begin
        reset = 1'b1;
        rf_init = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) set_cmd(i, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rf_init = 1'b0;
        settle();
        issue(0, 1, 2, 0, 'h5A); settle();
        issue(0, 0, 0, 2, 0); settle();
        issue(1, 1, 0, 0, 'h11); settle();
        issue(0, 1, 1, 0, 'h22); settle();
        issue(1, 3, 0, 1, 0); settle();
        set_cmd(0, 0, 0, 0, 0);
        set_cmd(1, 0, 0, 1, 0);
        req_valid = 2'b11;
        wait_total(acc_cnt[0] + acc_cnt[1] + 4);
        req_valid = '0;
        settle();
        issue(0, 1, 7, 0, 'hC3); settle();
        issue(1, 1, 3, 0, 'h7F); settle();
        issue(0, 2, 3, 3, 0); settle();
        issue(1, 3, 7, 7, 0); settle();
        issue(0, 3, 0, 1, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        set_cmd(1, 0, 0, 1, 0);
        req_valid = 2'b11;
        wait_total(acc_cnt[0] + acc_cnt[1] + 1);
        req_valid = '0;
        settle();
        for (int i = 0; i < N; i++) seen[i] = acc_cnt[i];
        repeat (600) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc_cnt[i] != seen[i]) req_valid[i] = 1'b0;
                seen[i] = acc_cnt[i];
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    set_cmd(i, int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(255)));
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid = '0;
        settle();
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single write port and single read port of the 8x8 CPU register file between NUM_REQ requesters (e.g. control unit, debug port).
- Sequences multi-cycle register operations over those ports: READ, WRITE-immediate, MOV and SWAP.
- Sits between the requesters and the register file, driving its sel_in/sel_out/enable_write/output_enable/data_in and sampling its data_out.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 8, register width.
- ADDR_W, 3, register index width (8 registers).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_op  in  NUM_REQ*2  per-requester op: 0 READ, 1 WRITE, 2 MOV, 3 SWAP
- req_rd  in  NUM_REQ*ADDR_W  destination index
- req_rs  in  NUM_REQ*ADDR_W  source index
- req_imm  in  NUM_REQ*DATA_W  WRITE immediate
- resp_valid  out  NUM_REQ  one-cycle completion pulse
- resp_data  out  DATA_W  result, qualified by resp_valid
- busy  out  1  high whenever state != IDLE
- rf_sel_in  out  ADDR_W  register file write index
- rf_sel_out  out  ADDR_W  register file read index
- rf_we  out  1  register file write enable
- rf_oe  out  1  register file output enable
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file read data (combinational)

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - RR pointer 0, so requester 0 has first priority.
  - tmp0/tmp1 cleared.
- Reset mid-operation aborts the op: no further rf_we, no resp_valid.
- FSM states: IDLE, S1, S2, S3, S4, RESP. Exactly one command is in flight at a time.
- IDLE:
  - If any req_valid, grant the first valid requester at or after the RR pointer (wrapping).
  - Pulse req_ready[g] for that cycle (cycle T) and latch op/rd/rs/imm and g.
  - Set the pointer to g+1 mod NUM_REQ.
  - Go to S1.
  - req_ready is never asserted outside IDLE.
- rf_oe is asserted only in read steps. rf_rdata is registered into tmp regs, never combinationally fed to rf_wdata.
- READ: S1: rf_oe=1, rf_sel_out=rs, tmp0<=rf_rdata -> RESP. resp_data=tmp0.
- WRITE: S1: rf_we=1, rf_sel_in=rd, rf_wdata=imm -> RESP. resp_data=imm.
- MOV:
  - S1: read rs into tmp0.
  - S2: write rd<=tmp0.
  - -> RESP. resp_data=tmp0.
- SWAP:
  - S1: read rs into tmp0.
  - S2: read rd into tmp1.
  - S3: write rd<=tmp0.
  - S4: write rs<=tmp1.
  - -> RESP. resp_data=tmp1 (old rd).
- RESP: resp_valid[g]=1 for one cycle, then IDLE. A new grant is possible on the next cycle.
- Latency from accept cycle T to resp_valid: READ T+2, WRITE T+2, MOV T+3, SWAP T+5.
- Throughput:
  - Back-to-back READs complete every 3 cycles.
  - A requester holding req_valid continuously cannot starve another: with both requesters valid, grants alternate.
- Boundary cases:
  - rd==rs MOV/SWAP execute normally and leave the register unchanged.
  - Index 7 (T register) is legal.
  - Requesters must hold req_valid and fields stable until req_ready; the block samples fields only in the accept cycle.
  - Unused rf outputs: rf_sel_in/rf_sel_out/rf_wdata hold 0 when not in use.

Decomposition:
- Shared package reg_arb_pkg holds:
  - op enum reg_op_e (OP_READ, OP_WRITE, OP_MOV, OP_SWAP).
  - state enum arb_state_e.
  - DATA_W/ADDR_W defaults.
- One natural sub-module: rr_arbiter, the round-robin grant logic with pointer update on accept.
- Op sequencing stays in the top-level FSM.

Test Plan:
- After reset, req0 WRITE rd=2 imm=0x5A -> req_ready[0] at T; rf_we=1, sel_in=2, wdata=0x5A at T+1; resp_valid[0] at T+2 with resp_data=0x5A.
- READ rs=2 (file holds 0x5A) -> rf_oe=1, sel_out=2 at T+1; resp_valid at T+2 with resp_data=0x5A; rf_we never asserted.
- Regs r0=0x11, r1=0x22; SWAP rd=0 rs=1 -> writes r0=0x22 at T+3 and r1=0x11 at T+4; resp_data=0x11 at T+5; ready never high while busy.
- req0 and req1 valid continuously with READs -> grant order 0,1,0,1; each accept 3 cycles apart; no double ready.
- MOV rd=3 rs=3 with r3=0x7F -> r3 stays 0x7F; resp_data=0x7F at T+3.
- reset asserted in S2 of SWAP -> no rf_we at the following edges; all outputs 0; r0/r1 hold prior values; next grant goes to req0.
